// File: rtl/matrix_alloc_if.sv
// matrix_alloc_if
// Groups every non-clock signal of the matrix slot allocator into one bundle.
//   master : the requester side (drives requests, commits, queries).
//   slave  : the allocator side (drives grants, query data, status).
// Signals:
//   alloc_*      allocation request and its same-cycle grant
//   commit_*     commit of the held reservation
//   abort_req    release the held reservation
//   clear_all    free every slot
//   config_per_dim  max stored matrices per (m,n) pair, 0 = unlimited
//   query_*      combinational slot readback
//   slot_count   registered number of VALID slots
//   err_pulse    one-cycle pulse on a rejected commit
//   dbg_*        controller state and held reservation, for observation
//
// Handshake: alloc is a same-cycle grant. alloc_valid/alloc_slot/alloc_addr
// are combinational from alloc_req and the table; a reservation is taken on
// the clock edge where alloc_req && alloc_valid are both 1. There is no
// backpressure on commit/abort: each is a single-cycle pulse sampled on the
// edge.
interface matrix_alloc_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  alloc_req;
  logic [3:0]            alloc_m;
  logic [3:0]            alloc_n;
  logic                  alloc_valid;
  logic [3:0]            alloc_slot;
  logic [ADDR_WIDTH-1:0] alloc_addr;
  logic                  commit_req;
  logic [3:0]            commit_slot;
  logic [3:0]            commit_m;
  logic [3:0]            commit_n;
  logic [ADDR_WIDTH-1:0] commit_addr;
  logic                  abort_req;
  logic                  clear_all;
  logic [3:0]            config_per_dim;
  logic [3:0]            query_slot;
  logic                  query_valid;
  logic [3:0]            query_m;
  logic [3:0]            query_n;
  logic [ADDR_WIDTH-1:0] query_addr;
  logic [3:0]            slot_count;
  logic                  err_pulse;
  logic                  dbg_hold;
  logic [3:0]            dbg_res_slot;
  logic [3:0]            dbg_res_m;
  logic [3:0]            dbg_res_n;

  modport master (
    output alloc_req, alloc_m, alloc_n,
    output commit_req, commit_slot, commit_m, commit_n, commit_addr,
    output abort_req, clear_all, config_per_dim, query_slot,
    input  alloc_valid, alloc_slot, alloc_addr,
    input  query_valid, query_m, query_n, query_addr,
    input  slot_count, err_pulse,
    input  dbg_hold, dbg_res_slot, dbg_res_m, dbg_res_n
  );

  modport slave (
    input  alloc_req, alloc_m, alloc_n,
    input  commit_req, commit_slot, commit_m, commit_n, commit_addr,
    input  abort_req, clear_all, config_per_dim, query_slot,
    output alloc_valid, alloc_slot, alloc_addr,
    output query_valid, query_m, query_n, query_addr,
    output slot_count, err_pulse,
    output dbg_hold, dbg_res_slot, dbg_res_m, dbg_res_n
  );
endinterface

// File: rtl/matrix_alloc_ctrl.sv
// matrix_alloc_ctrl
// Allocates fixed-size BRAM regions ("slots") to matrices. A requester asks
// for a slot, gets a same-cycle grant, fills the region, then commits it.
// Only one reservation can be outstanding. When the table is full (or the
// per-dimension limit is hit) the oldest matching/any VALID slot is evicted
// at reservation time.
// Ports:
//   clk    single clock
//   rst_n  asynchronous active-low reset
//   bus    matrix_alloc_if.slave (requests, grants, queries, status)
module matrix_alloc_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_SLOTS  = 8,
  parameter int SLOT_SHIFT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  matrix_alloc_if.slave  bus
);

  typedef enum logic [1:0] {S_FREE = 2'd0, S_RES = 2'd1, S_VALID = 2'd2} slot_st_t;
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} fsm_t;

  // Tables are sized for the 4-bit slot index; entries >= NUM_SLOTS stay at
  // reset values and are masked out on the query path.
  slot_st_t   st_q  [16];
  logic [3:0] m_q   [16];
  logic [3:0] n_q   [16];
  logic [3:0] age_q [16];

  fsm_t       state_q;
  logic [3:0] res_slot_q, res_m_q, res_n_q;
  logic [3:0] slot_count_q;
  logic       err_q;

  function automatic logic [ADDR_WIDTH-1:0] base_addr(input logic [3:0] k);
    base_addr = {{(ADDR_WIDTH-4){1'b0}}, k} << SLOT_SHIFT;
  endfunction

  // Victim search and VALID count
  logic [4:0] match_cnt;
  logic [3:0] valid_cnt;
  logic       free_found, old_found;
  logic [3:0] free_idx, old_idx, old_age, mt_idx, mt_age;
  logic       mt_found;
  logic [3:0] victim;
  logic       victim_ok;

  always_comb begin
    match_cnt  = '0;
    valid_cnt  = '0;
    free_found = 1'b0;
    free_idx   = '0;
    old_found  = 1'b0;
    old_idx    = '0;
    old_age    = '0;
    mt_found   = 1'b0;
    mt_idx     = '0;
    mt_age     = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (st_q[i] == S_VALID) begin
        valid_cnt = valid_cnt + 4'd1;
        // Strict '>' keeps the lowest index on equal age.
        if (!old_found || age_q[i] > old_age) begin
          old_found = 1'b1;
          old_idx   = 4'(i);
          old_age   = age_q[i];
        end
        if (m_q[i] == bus.alloc_m && n_q[i] == bus.alloc_n) begin
          match_cnt = match_cnt + 5'd1;
          if (!mt_found || age_q[i] > mt_age) begin
            mt_found = 1'b1;
            mt_idx   = 4'(i);
            mt_age   = age_q[i];
          end
        end
      end else if (st_q[i] == S_FREE && !free_found) begin
        free_found = 1'b1;
        free_idx   = 4'(i);
      end
    end

    victim    = '0;
    victim_ok = 1'b0;
    if (bus.config_per_dim != 4'd0 && match_cnt >= {1'b0, bus.config_per_dim}) begin
      victim    = mt_idx;
      victim_ok = mt_found;
    end else if (free_found) begin
      victim    = free_idx;
      victim_ok = 1'b1;
    end else begin
      victim    = old_idx;
      victim_ok = old_found;
    end
  end

  logic alloc_ok;
  logic commit_ok;

  assign alloc_ok  = (state_q == IDLE) && (bus.alloc_m != 4'd0) &&
                     (bus.alloc_n != 4'd0) && victim_ok;
  assign commit_ok = (state_q == HOLD) && bus.commit_req &&
                     (bus.commit_slot == res_slot_q) &&
                     (bus.commit_addr == base_addr(res_slot_q));

  assign bus.alloc_valid = alloc_ok;
  assign bus.alloc_slot  = victim;
  assign bus.alloc_addr  = base_addr(victim);

  logic q_in_range;
  assign q_in_range      = ({28'd0, bus.query_slot} < NUM_SLOTS);
  assign bus.query_valid = q_in_range && (st_q[bus.query_slot] == S_VALID);
  assign bus.query_m     = q_in_range ? m_q[bus.query_slot] : 4'd0;
  assign bus.query_n     = q_in_range ? n_q[bus.query_slot] : 4'd0;
  assign bus.query_addr  = q_in_range ? base_addr(bus.query_slot) : '0;

  assign bus.slot_count   = slot_count_q;
  assign bus.err_pulse    = err_q;
  assign bus.dbg_hold     = (state_q == HOLD);
  assign bus.dbg_res_slot = res_slot_q;
  assign bus.dbg_res_m    = res_m_q;
  assign bus.dbg_res_n    = res_n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        st_q[i]  <= S_FREE;
        m_q[i]   <= '0;
        n_q[i]   <= '0;
        age_q[i] <= '0;
      end
      state_q      <= IDLE;
      res_slot_q   <= '0;
      res_m_q      <= '0;
      res_n_q      <= '0;
      slot_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q        <= 1'b0;
      // Lags the table by one edge.
      slot_count_q <= valid_cnt;
      if (bus.clear_all) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          st_q[i]  <= S_FREE;
          age_q[i] <= '0;
        end
        state_q <= IDLE;
      end else begin
        if (bus.commit_req && !commit_ok) err_q <= 1'b1;
        case (state_q)
          IDLE: begin
            if (bus.alloc_req && alloc_ok) begin
              st_q[victim] <= S_RES;
              res_slot_q   <= victim;
              res_m_q      <= bus.alloc_m;
              res_n_q      <= bus.alloc_n;
              state_q      <= HOLD;
            end
          end
          HOLD: begin
            // An accepted commit takes precedence over a same-cycle abort.
            if (commit_ok) begin
              for (int i = 0; i < NUM_SLOTS; i++) begin
                if (4'(i) == res_slot_q) begin
                  st_q[i]  <= S_VALID;
                  m_q[i]   <= bus.commit_m;
                  n_q[i]   <= bus.commit_n;
                  age_q[i] <= '0;
                end else if (st_q[i] == S_VALID && age_q[i] < 4'(NUM_SLOTS-1)) begin
                  age_q[i] <= age_q[i] + 4'd1;
                end
              end
              state_q <= IDLE;
            end else if (bus.abort_req) begin
              st_q[res_slot_q] <= S_FREE;
              state_q          <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_alloc_ctrl.sv
module tb_matrix_alloc_ctrl;

  logic clk;
  logic rst_n;

  matrix_alloc_if #(.ADDR_WIDTH(11)) bus ();

  matrix_alloc_ctrl #(
    .ADDR_WIDTH(11),
    .NUM_SLOTS (8),
    .SLOT_SHIFT(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] base_of(input logic [3:0] s);
    base_of = 32'(s) * 32'd256;
  endfunction

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [3:0] m, input logic [3:0] n,
                          input logic exp_v, input logic [3:0] exp_s, input string tag);
    bus.alloc_req = 1'b1;
    bus.alloc_m   = m;
    bus.alloc_n   = n;
    #1;
    check({tag, ".valid"}, 32'(bus.alloc_valid), 32'(exp_v));
    if (exp_v) begin
      check({tag, ".slot"}, 32'(bus.alloc_slot), 32'(exp_s));
      check({tag, ".addr"}, 32'(bus.alloc_addr), base_of(exp_s));
    end
    tick();
    bus.alloc_req = 1'b0;
    bus.alloc_m   = '0;
    bus.alloc_n   = '0;
  endtask

  task automatic do_commit(input logic [3:0] s, input logic [3:0] m, input logic [3:0] n,
                           input logic [10:0] addr, input logic with_abort);
    bus.commit_req  = 1'b1;
    bus.commit_slot = s;
    bus.commit_m    = m;
    bus.commit_n    = n;
    bus.commit_addr = addr;
    bus.abort_req   = with_abort;
    tick();
    bus.commit_req  = 1'b0;
    bus.abort_req   = 1'b0;
  endtask

  task automatic do_abort();
    bus.abort_req = 1'b1;
    tick();
    bus.abort_req = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear_all = 1'b1;
    tick();
    bus.clear_all = 1'b0;
  endtask

  task automatic store(input logic [3:0] m, input logic [3:0] n, input logic [3:0] s, input string tag);
    do_alloc(m, n, 1'b1, s, tag);
    do_commit(s, m, n, 11'(base_of(s)), 1'b0);
  endtask

  task automatic q_check(input logic [3:0] s, input logic exp_v, input logic [3:0] em,
                         input logic [3:0] en, input logic [31:0] ea, input string tag);
    bus.query_slot = s;
    #1;
    check({tag, ".qvalid"}, 32'(bus.query_valid), 32'(exp_v));
    check({tag, ".qm"},     32'(bus.query_m), 32'(em));
    check({tag, ".qn"},     32'(bus.query_n), 32'(en));
    check({tag, ".qaddr"},  32'(bus.query_addr), ea);
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.alloc_req      = 1'b0;
    bus.alloc_m        = '0;
    bus.alloc_n        = '0;
    bus.commit_req     = 1'b0;
    bus.commit_slot    = '0;
    bus.commit_m       = '0;
    bus.commit_n       = '0;
    bus.commit_addr    = '0;
    bus.abort_req      = 1'b0;
    bus.clear_all      = 1'b0;
    bus.config_per_dim = '0;
    bus.query_slot     = '0;

    // reset state
    #12;
    check("rst.count", 32'(bus.slot_count), 32'd0);
    check("rst.err",   32'(bus.err_pulse), 32'd0);
    check("rst.hold",  32'(bus.dbg_hold), 32'd0);
    check("rst.qvalid", 32'(bus.query_valid), 32'd0);
    check("rst.allocv_m0", 32'(bus.alloc_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // basic allocate / commit
    do_alloc(4'd2, 4'd3, 1'b1, 4'd0, "basic.alloc");
    check("basic.hold", 32'(bus.dbg_hold), 32'd1);
    q_check(4'd0, 1'b0, 4'd0, 4'd0, 32'h000, "basic.reserved");
    do_commit(4'd0, 4'd2, 4'd3, 11'h000, 1'b0);
    check("basic.hold_after", 32'(bus.dbg_hold), 32'd0);
    check("basic.err", 32'(bus.err_pulse), 32'd0);
    q_check(4'd0, 1'b1, 4'd2, 4'd3, 32'h000, "basic.q0");
    check("basic.count_lag", 32'(bus.slot_count), 32'd0);
    tick();
    check("basic.count", 32'(bus.slot_count), 32'd1);

    // blocked while held, bad commits, abort
    do_alloc(4'd1, 4'd1, 1'b1, 4'd1, "held.alloc");
    do_alloc(4'd2, 4'd2, 1'b0, 4'd0, "held.blocked");
    do_commit(4'd2, 4'd1, 4'd1, 11'h200, 1'b0);
    check("held.err_slot", 32'(bus.err_pulse), 32'd1);
    check("held.still_hold", 32'(bus.dbg_hold), 32'd1);
    tick();
    check("held.err_clear", 32'(bus.err_pulse), 32'd0);
    do_commit(4'd1, 4'd1, 4'd1, 11'h000, 1'b0);
    check("held.err_addr", 32'(bus.err_pulse), 32'd1);
    check("held.hold2", 32'(bus.dbg_hold), 32'd1);
    do_abort();
    check("held.abort_idle", 32'(bus.dbg_hold), 32'd0);
    check("held.err_abort", 32'(bus.err_pulse), 32'd0);
    q_check(4'd1, 1'b0, 4'd0, 4'd0, 32'h100, "held.q1");
    tick();
    check("held.count", 32'(bus.slot_count), 32'd1);
    do_abort();
    check("idle_abort.err", 32'(bus.err_pulse), 32'd0);
    do_alloc(4'd1, 4'd1, 1'b1, 4'd1, "held.free_again");
    do_abort();

    // per-dimension eviction
    do_clear();
    tick();
    check("pd.count0", 32'(bus.slot_count), 32'd0);
    bus.config_per_dim = 4'd2;
    store(4'd2, 4'd2, 4'd0, "pd.a");
    store(4'd2, 4'd2, 4'd1, "pd.b");
    do_alloc(4'd2, 4'd2, 1'b1, 4'd0, "pd.third");
    do_commit(4'd0, 4'd2, 4'd2, 11'h000, 1'b0);
    do_alloc(4'd2, 4'd2, 1'b1, 4'd1, "pd.fourth");
    do_abort();
    bus.config_per_dim = 4'd0;
    do_alloc(4'd2, 4'd2, 1'b1, 4'd1, "pd.unlimited");
    do_abort();
    do_alloc(4'd0, 4'd2, 1'b0, 4'd0, "pd.m0");

    // full-table eviction
    do_clear();
    for (int i = 0; i < 8; i++) exp_q.push_back(4'(i));
    for (int i = 0; i < 8; i++) begin
      logic [3:0] s;
      s = exp_q.pop_front();
      store(4'(i + 1), 4'(i + 2), s, "full.fill");
    end
    tick();
    check("full.count", 32'(bus.slot_count), 32'd8);
    do_alloc(4'd9, 4'd9, 1'b1, 4'd0, "full.evict0");
    do_commit(4'd0, 4'd9, 4'd9, 11'h000, 1'b0);
    do_alloc(4'd9, 4'd8, 1'b1, 4'd1, "full.evict1");
    do_commit(4'd1, 4'd9, 4'd8, 11'h100, 1'b0);
    do_alloc(4'd7, 4'd7, 1'b1, 4'd2, "full.evict2");
    // commit and abort together: the accepted commit wins
    do_commit(4'd2, 4'd7, 4'd7, 11'h200, 1'b1);
    q_check(4'd2, 1'b1, 4'd7, 4'd7, 32'h200, "sim.q2");
    check("sim.err", 32'(bus.err_pulse), 32'd0);
    q_check(4'd8, 1'b0, 4'd0, 4'd0, 32'h000, "q.range8");
    q_check(4'd15, 1'b0, 4'd0, 4'd0, 32'h000, "q.range15");

    // reset while holding
    do_alloc(4'd3, 4'd3, 1'b1, 4'd3, "rsth.alloc");
    #3;
    rst_n = 1'b0;
    #1;
    check("rsth.hold", 32'(bus.dbg_hold), 32'd0);
    check("rsth.count", 32'(bus.slot_count), 32'd0);
    check("rsth.err", 32'(bus.err_pulse), 32'd0);
    q_check(4'd0, 1'b0, 4'd0, 4'd0, 32'h000, "rsth.q0");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_alloc(4'd3, 4'd3, 1'b1, 4'd0, "rsth.next");
    do_abort();

    // clear_all with 5 VALID slots, plus ignored alloc/commit in that cycle
    for (int i = 0; i < 5; i++) store(4'd4, 4'(i + 1), 4'(i), "clr.fill");
    tick();
    check("clr.count5", 32'(bus.slot_count), 32'd5);
    bus.clear_all   = 1'b1;
    bus.alloc_req   = 1'b1;
    bus.alloc_m     = 4'd5;
    bus.alloc_n     = 4'd5;
    bus.commit_req  = 1'b1;
    bus.commit_slot = 4'd6;
    tick();
    bus.clear_all  = 1'b0;
    bus.alloc_req  = 1'b0;
    bus.alloc_m    = '0;
    bus.alloc_n    = '0;
    bus.commit_req = 1'b0;
    check("clr.hold", 32'(bus.dbg_hold), 32'd0);
    check("clr.err", 32'(bus.err_pulse), 32'd0);
    q_check(4'd0, 1'b0, 4'd4, 4'd1, 32'h000, "clr.q0");
    tick();
    check("clr.count0", 32'(bus.slot_count), 32'd0);
    do_alloc(4'd0, 4'd3, 1'b0, 4'd0, "clr.m0");
    do_alloc(4'd1, 4'd1, 1'b1, 4'd0, "clr.after");
    do_abort();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_alloc_ctrl.md
MATRIX_ALLOC_CTRL -- requirements
Module: matrix_alloc_ctrl

Parameters
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 11, giving the BRAM word-address width.
REQ-002 The block SHALL have parameter NUM_SLOTS, default 8, giving the number of matrix slots (2..16).
REQ-003 The block SHALL have parameter SLOT_SHIFT, default 8, giving the log2 of the words per slot region.

Interface
REQ-004 The block SHALL have ports:
- clk  in  1  the single clock.
- rst_n  in  1  asynchronous active-low reset.
- alloc_req  in  1  allocation request.
- alloc_m, alloc_n  in  4 each  requested dimensions.
- alloc_valid  out  1  grant for the current alloc_req.
- alloc_slot  out  4  granted slot.
- alloc_addr  out  ADDR_WIDTH  granted base address.
- commit_req  in  1  commit pulse.
- commit_slot  in  4  slot being committed.
- commit_m, commit_n  in  4 each  committed dimensions.
- commit_addr  in  ADDR_WIDTH  committed base address.
- abort_req  in  1  release the held reservation.
- clear_all  in  1  free every slot.
- config_per_dim  in  4  maximum stored matrices per (m,n) pair; 0 = unlimited.
- query_slot  in  4  slot to read.
- query_valid  out  1  queried slot is VALID.
- query_m, query_n  out  4 each  dimensions of the queried slot.
- query_addr  out  ADDR_WIDTH  base address of the queried slot.
- slot_count  out  4  number of VALID slots.
- err_pulse  out  1  one-cycle pulse on a protocol violation.

Function
REQ-005 Each slot SHALL hold: state (FREE/RESERVED/VALID), m, n, and a 4-bit age.
REQ-006 The base address of slot k SHALL be k << SLOT_SHIFT, zero-extended to ADDR_WIDTH.
REQ-007 The controller FSM SHALL have two states:
- IDLE: no reservation held.
- HOLD: exactly one slot RESERVED, recorded as res_slot, res_m, res_n.
REQ-008 alloc_valid, alloc_slot and alloc_addr SHALL be combinational in the same cycle as alloc_req; alloc_slot and alloc_addr are don't-care when alloc_valid is 0.
REQ-009 alloc_valid SHALL be 0 in any of these cases: FSM in HOLD; alloc_m or alloc_n equal to 0; no victim exists.
REQ-010 Victim selection SHALL use the first applicable rule, in this order:
- (a) If config_per_dim != 0 and the number of VALID slots with m,n equal to alloc_m,alloc_n is >= config_per_dim: the oldest such slot.
- (b) Otherwise, the lowest-index FREE slot.
- (c) Otherwise, the oldest VALID slot.
REQ-011 "Oldest" SHALL mean the maximum age, with ties broken by the lowest index.
REQ-012 On a clock edge with alloc_req=1 and alloc_valid=1, the victim SHALL become RESERVED, res_* SHALL be latched, and the FSM SHALL go to HOLD.
REQ-013 A RESERVED slot SHALL report query_valid=0 and SHALL never be selected as a victim.
REQ-014 A commit SHALL be accepted when the FSM is in HOLD and commit_req=1 and commit_slot=res_slot and commit_addr equals that slot's base address.
REQ-015 On an accepted commit:
- the slot becomes VALID with m,n taken from commit_m,commit_n;
- the slot's age is set to 0;
- every other VALID slot's age increments, saturating at NUM_SLOTS-1;
- the FSM returns to IDLE.
REQ-016 Any commit_req not accepted SHALL be ignored and SHALL pulse err_pulse for one cycle.
REQ-017 abort_req in HOLD SHALL set the RESERVED slot to FREE and return the FSM to IDLE.
REQ-018 abort_req in IDLE SHALL be ignored and SHALL NOT pulse err_pulse.
REQ-019 When commit_req and abort_req are both 1 in the same cycle, an accepted commit SHALL win over the abort.
REQ-020 clear_all SHALL have the highest priority: on the next edge all slots become FREE with age 0, the FSM goes to IDLE, and alloc/commit/abort in that cycle are ignored with no err_pulse.
REQ-021 slot_count SHALL be a registered count of VALID slots, updated on the edge after the change.
REQ-022 The query outputs SHALL be combinational from query_slot.
REQ-023 A query_slot >= NUM_SLOTS SHALL return query_valid=0 and zeros on the other query outputs.
REQ-024 Overwriting an evicted VALID slot's data is the requester's responsibility; eviction SHALL take effect at reservation time.

Reset
REQ-025 While rst_n=0, asynchronously:
- all slots FREE, with m=0, n=0, age=0;
- FSM in IDLE;
- res_* = 0;
- slot_count=0 and err_pulse=0.
REQ-026 The combinational outputs SHALL reflect the reset table state (alloc_valid follows REQ-009).
REQ-027 Reset asserted in HOLD SHALL discard the reservation.

Verification
REQ-028 Basic allocate and commit:
- After reset, alloc 2x3 -> alloc_valid=1, slot 0, addr 0x000.
- Commit slot 0, addr 0x000, dims 2x3 -> query_slot=0 gives valid=1, 2x3; slot_count=1 one cycle later.
REQ-029 Per-dimension eviction:
- With config_per_dim=2, commit three 2x2 matrices.
- The third alloc returns slot 0 (oldest 2x2) even though slots 2..7 are FREE.
REQ-030 Full-table eviction:
- Fill all 8 slots with distinct dimensions, config_per_dim=0.
- The next alloc returns the oldest slot (slot 0), addr 0x000.
REQ-031 Allocation blocked while held:
- While in HOLD, alloc_req -> alloc_valid=0.
- Commit to the wrong slot -> err_pulse=1 for one cycle and the FSM stays in HOLD.
- Abort -> the slot returns to FREE and slot_count is unchanged.
REQ-032 Simultaneous and reset cases:
- commit_req and abort_req in the same cycle with a matching commit -> slot VALID.
- rst_n pulsed low in HOLD -> all outputs at reset values and the next alloc returns slot 0.
REQ-033 clear_all with 5 VALID slots -> slot_count=0 next cycle, and alloc_m=0 gives alloc_valid=0.
